// File: rtl/seg7_pkg.sv
// Shared glyph and polarity constants for the multiplexed 7-segment display driver.
// Segment vectors are active-low, ordered a..g from bit 6 down to bit 0.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic SEG_ON    = 1'b0;
  localparam logic SEG_OFF   = 1'b1;
  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  localparam seg7_t SEG_0     = 7'b0000001;
  localparam seg7_t SEG_1     = 7'b1001111;
  localparam seg7_t SEG_2     = 7'b0010010;
  localparam seg7_t SEG_3     = 7'b0000110;
  localparam seg7_t SEG_4     = 7'b1001100;
  localparam seg7_t SEG_5     = 7'b0100100;
  localparam seg7_t SEG_6     = 7'b0100000;
  localparam seg7_t SEG_7     = 7'b0001111;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0000100;
  localparam seg7_t SEG_A     = 7'b0001000;
  localparam seg7_t SEG_B     = 7'b1100000;
  localparam seg7_t SEG_C     = 7'b0110001;
  localparam seg7_t SEG_D     = 7'b1000010;
  localparam seg7_t SEG_E     = 7'b0110000;
  localparam seg7_t SEG_F     = 7'b0111000;
  localparam seg7_t SEG_DASH  = 7'b1111110;
  localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-glyph encoder; codes 10-15 show A..F in hex mode,
// otherwise a dash.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'd0:  seg_o = SEG_0;
      4'd1:  seg_o = SEG_1;
      4'd2:  seg_o = SEG_2;
      4'd3:  seg_o = SEG_3;
      4'd4:  seg_o = SEG_4;
      4'd5:  seg_o = SEG_5;
      4'd6:  seg_o = SEG_6;
      4'd7:  seg_o = SEG_7;
      4'd8:  seg_o = SEG_8;
      4'd9:  seg_o = SEG_9;
      4'd10: seg_o = hex_mode_i ? SEG_A : SEG_DASH;
      4'd11: seg_o = hex_mode_i ? SEG_B : SEG_DASH;
      4'd12: seg_o = hex_mode_i ? SEG_C : SEG_DASH;
      4'd13: seg_o = hex_mode_i ? SEG_D : SEG_DASH;
      4'd14: seg_o = hex_mode_i ? SEG_E : SEG_DASH;
      4'd15: seg_o = hex_mode_i ? SEG_F : SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver with per-frame input
// snapshot, leading-zero blanking and an anti-ghosting blank window per slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          HEX_MODE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int unsigned   CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned   IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW:0]   BLANK_LIM = (CW + 1)'(BLANK_CYCLES);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    load_pending_q;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_en_q;
  logic                    snap_lzb_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_start_q;

  logic                    tick, load, blank_win;
  logic                    lz_run;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_en, cur_lzb;
  logic [6:0]              glyph;

  assign tick      = (cnt_q == CNT_LAST);
  assign load      = load_pending_q | (tick & (idx_q == IDX_LAST));
  assign blank_win = ({1'b0, cnt_q} < BLANK_LIM);
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign idx_d     = !tick ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1);

  // Blanking run walks down from the MSD; any non-zero nibble or lit dp ends it.
  always_comb begin
    lz_run   = snap_lzb_q;
    lz_blank = '0;
    for (int unsigned j = NUM_DIGITS; j > 0; j--) begin
      lz_run        = lz_run && (snap_digits_q[4*(j-1) +: 4] == 4'd0) && !snap_dp_q[j-1];
      lz_blank[j-1] = lz_run && (j != 1);
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lzb = 1'b0;
    anode_d = {NUM_DIGITS{ANODE_OFF}};
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib    = snap_digits_q[4*i +: 4];
        cur_dp     = snap_dp_q[i];
        cur_en     = snap_en_q[i];
        cur_lzb    = lz_blank[i];
        anode_d[i] = ANODE_ON;
      end
    end
  end

  seg7_encode u_encode (
    .nibble_i   (cur_nib),
    .hex_mode_i (HEX_MODE),
    .seg_o      (glyph)
  );

  always_comb begin
    seg_d  = (cur_en && !cur_lzb) ? glyph : SEG_BLANK;
    dp_n_d = (cur_en && cur_dp) ? SEG_ON : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      snap_digits_q  <= '0;
      snap_dp_q      <= '0;
      snap_en_q      <= '0;
      snap_lzb_q     <= 1'b0;
      seg_q          <= SEG_BLANK;
      dp_n_q         <= SEG_OFF;
      anode_q        <= {NUM_DIGITS{ANODE_OFF}};
      frame_start_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      load_pending_q <= 1'b0;
      frame_start_q  <= load;
      if (load) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp;
        snap_en_q     <= digit_en;
        snap_lzb_q    <= lzb;
      end
      if (blank_win) begin
        seg_q   <= SEG_BLANK;
        dp_n_q  <= SEG_OFF;
        anode_q <= {NUM_DIGITS{ANODE_OFF}};
      end else begin
        seg_q   <= seg_d;
        dp_n_q  <= dp_n_d;
        anode_q <= anode_d;
      end
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign anode       = anode_q;
  assign frame_start = frame_start_q;

endmodule
